npc_mem_arbiter: RTL and testbench

//  Shares the single NPC physical-memory port between instruction fetch (IFU, read-only) and the

---
 rtl/npc_mem_arbiter_if.sv | 53 +++++
 rtl/npc_mem_arbiter.sv | 118 +++++++++++
 tb/tb_npc_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the pmem bridge.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface npc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
    );
endinterface

// File: rtl/npc_mem_arbiter.sv
// Single-outstanding arbiter sharing the NPC pmem port between IFU and LSU.
// Define NPC_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module npc_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                reset,
    npc_mem_arbiter_if.slave    bus,
    output logic                timeout_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q, state_d;
    logic              grant_lsu_q, grant_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;
    logic              pick_lsu;

    // grant_lsu_q doubles as last_grant: it is only rewritten on a grant
`ifdef NPC_ARB_RR_EN
    assign pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !grant_lsu_q);
`else
    assign pick_lsu = bus.lsu_req_valid;
`endif

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d            = state_q;
        grant_lsu_d        = grant_lsu_q;
        addr_d             = addr_q;
        wen_d              = wen_q;
        wdata_d            = wdata_q;
        wmask_d            = wmask_q;
        cnt_d              = cnt_q;
        err_d              = err_q;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.lsu_rdata      = '0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ifu_req_valid || bus.lsu_req_valid) begin
                    // req_ready is gated by reset so every output reads 0 while reset is held
                    bus.ifu_req_ready = reset && !pick_lsu;
                    bus.lsu_req_ready = reset && pick_lsu;
                    grant_lsu_d       = pick_lsu;
                    addr_d            = pick_lsu ? bus.lsu_addr  : bus.ifu_addr;
                    wen_d             = pick_lsu && bus.lsu_wen;
                    wdata_d           = pick_lsu ? bus.lsu_wdata : '0;
                    wmask_d           = pick_lsu ? bus.lsu_wmask : '0;
                    cnt_d             = '0;
                    state_d           = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = RESP;
            end
            RESP: begin
                bus.ifu_resp_valid = !grant_lsu_q && bus.mem_resp_valid;
                bus.lsu_resp_valid = grant_lsu_q && bus.mem_resp_valid;
                bus.ifu_rdata      = grant_lsu_q ? '0 : bus.mem_rdata;
                bus.lsu_rdata      = grant_lsu_q ? bus.mem_rdata : '0;
                bus.mem_resp_ready = grant_lsu_q ? bus.lsu_resp_ready : bus.ifu_resp_ready;
                if (bus.mem_resp_valid && bus.mem_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Watchdog saturates at the limit; the sticky flag never disturbs the FSM
        if (state_q != IDLE) begin
            if (cnt_q != TO_VAL) cnt_d = cnt_inc;
            if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_lsu_q <= 1'b1;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_lsu_q <= grant_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
    assign timeout_err   = err_q;
endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed and randomized bench for npc_mem_arbiter, checked against a transaction-level model.
// Honours NPC_ARB_RR_EN the same way the design does.
module tb_npc_mem_arbiter;
    localparam int TO = 8;
`ifdef NPC_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic timeout_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    npc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Model state: pending requests per master, last grant, expected sticky error
    bit          ifu_pend, lsu_pend, last_lsu_m, exp_err;
    logic [31:0] ifu_a, lsu_a, lsu_wd;
    logic        lsu_w;
    logic [3:0]  lsu_wm;

    function automatic bit pick_lsu_m(bit iv, bit lv, bit last_lsu);
        if (iv && lv) return RR_MODE ? !last_lsu : 1'b1;
        return lv;
    endfunction

    task automatic chk1(string tag, logic obs, logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(string nm);
        chk1({nm, ".ifu_req_ready"}, bus.ifu_req_ready, 1'b0);
        chk1({nm, ".lsu_req_ready"}, bus.lsu_req_ready, 1'b0);
        chk1({nm, ".ifu_resp_valid"}, bus.ifu_resp_valid, 1'b0);
        chk1({nm, ".lsu_resp_valid"}, bus.lsu_resp_valid, 1'b0);
        chk32({nm, ".ifu_rdata"}, bus.ifu_rdata, 32'h0);
        chk32({nm, ".lsu_rdata"}, bus.lsu_rdata, 32'h0);
        chk1({nm, ".mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk32({nm, ".mem_addr"}, bus.mem_addr, 32'h0);
        chk1({nm, ".mem_wen"}, bus.mem_wen, 1'b0);
        chk32({nm, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        chk32({nm, ".mem_wmask"}, 32'(bus.mem_wmask), 32'h0);
        chk1({nm, ".mem_resp_ready"}, bus.mem_resp_ready, 1'b0);
        chk1({nm, ".timeout_err"}, timeout_err, 1'b0);
    endtask

    // One full transaction from an IDLE cycle; called at posedge+1.
    task automatic serve(string nm, int d_req, int d_gap, int d_rsp, bit rnd_rd, logic [31:0] rd_fix);
        bit          win_lsu, last_rsp;
        int          b;
        logic [31:0] e_addr, e_wd, rd;
        logic        e_wen;
        logic [3:0]  e_wm;
        win_lsu = pick_lsu_m(ifu_pend, lsu_pend, last_lsu_m);
        e_addr  = win_lsu ? lsu_a : ifu_a;
        e_wen   = win_lsu ? lsu_w : 1'b0;
        e_wd    = win_lsu ? lsu_wd : 32'h0;
        e_wm    = win_lsu ? lsu_wm : 4'h0;
        bus.ifu_req_valid  = ifu_pend;
        bus.ifu_addr       = ifu_a;
        bus.lsu_req_valid  = lsu_pend;
        bus.lsu_addr       = lsu_a;
        bus.lsu_wen        = lsu_w;
        bus.lsu_wdata      = lsu_wd;
        bus.lsu_wmask      = lsu_wm;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.ifu_resp_ready = 1'($urandom);
        bus.lsu_resp_ready = 1'($urandom);
        #2;
        chk1({nm, ".ifu_req_ready"}, bus.ifu_req_ready, !win_lsu);
        chk1({nm, ".lsu_req_ready"}, bus.lsu_req_ready, win_lsu);
        chk1({nm, ".idle_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk1({nm, ".idle_mem_resp_ready"}, bus.mem_resp_ready, 1'b0);
        chk1({nm, ".idle_ifu_resp_valid"}, bus.ifu_resp_valid, 1'b0);
        chk1({nm, ".idle_lsu_resp_valid"}, bus.lsu_resp_valid, 1'b0);
        chk1({nm, ".idle_timeout_err"}, timeout_err, exp_err);
        tick();
        if (win_lsu) begin lsu_pend = 1'b0; bus.lsu_req_valid = 1'b0; end
        else         begin ifu_pend = 1'b0; bus.ifu_req_valid = 1'b0; end
        last_lsu_m = win_lsu;
        b = 0;
        for (int i = 0; i <= d_req; i++) begin
            b++;
            if (b - 1 >= TO) exp_err = 1'b1;
            bus.mem_req_ready = (i == d_req);
            #2;
            chk1({nm, ".mem_req_valid"}, bus.mem_req_valid, 1'b1);
            chk32({nm, ".mem_addr"}, bus.mem_addr, e_addr);
            chk1({nm, ".mem_wen"}, bus.mem_wen, e_wen);
            chk32({nm, ".mem_wdata"}, bus.mem_wdata, e_wd);
            chk32({nm, ".mem_wmask"}, 32'(bus.mem_wmask), 32'(e_wm));
            chk1({nm, ".req_ifu_req_ready"}, bus.ifu_req_ready, 1'b0);
            chk1({nm, ".req_lsu_req_ready"}, bus.lsu_req_ready, 1'b0);
            chk1({nm, ".req_mem_resp_ready"}, bus.mem_resp_ready, 1'b0);
            chk1({nm, ".req_timeout_err"}, timeout_err, exp_err);
            tick();
        end
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < d_gap; i++) begin
            b++;
            if (b - 1 >= TO) exp_err = 1'b1;
            #2;
            chk1({nm, ".gap_mem_req_valid"}, bus.mem_req_valid, 1'b0);
            chk1({nm, ".gap_ifu_resp_valid"}, bus.ifu_resp_valid, 1'b0);
            chk1({nm, ".gap_lsu_resp_valid"}, bus.lsu_resp_valid, 1'b0);
            chk1({nm, ".gap_req_ready"}, bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
            tick();
        end
        for (int i = 0; i <= d_rsp; i++) begin
            b++;
            if (b - 1 >= TO) exp_err = 1'b1;
            last_rsp = (i == d_rsp);
            rd = rnd_rd ? $urandom : rd_fix;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = rd;
            bus.ifu_resp_ready = win_lsu ? 1'($urandom) : last_rsp;
            bus.lsu_resp_ready = win_lsu ? last_rsp : 1'($urandom);
            #2;
            chk1({nm, ".ifu_resp_valid"}, bus.ifu_resp_valid, !win_lsu);
            chk1({nm, ".lsu_resp_valid"}, bus.lsu_resp_valid, win_lsu);
            chk32({nm, ".rdata"}, win_lsu ? bus.lsu_rdata : bus.ifu_rdata, rd);
            chk1({nm, ".mem_resp_ready"}, bus.mem_resp_ready, last_rsp);
            chk1({nm, ".rsp_req_ready"}, bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
            chk1({nm, ".rsp_timeout_err"}, timeout_err, exp_err);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.ifu_resp_ready = 1'b0;
        bus.lsu_resp_ready = 1'b0;
        if (b >= TO) exp_err = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.ifu_req_valid = 1'b1;  bus.ifu_addr = 32'h8000_0000;  bus.ifu_resp_ready = 1'b1;
        bus.lsu_req_valid = 1'b1;  bus.lsu_addr = 32'h8000_1000;  bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 32'h1234_5678;  bus.lsu_wmask = 4'hF;  bus.lsu_resp_ready = 1'b1;
        bus.mem_req_ready = 1'b1;  bus.mem_resp_valid = 1'b1;  bus.mem_rdata = 32'hDEAD_BEEF;
        ifu_pend = 1'b0;  lsu_pend = 1'b0;  last_lsu_m = 1'b1;  exp_err = 1'b0;
        ifu_a = '0;  lsu_a = '0;  lsu_wd = '0;  lsu_w = 1'b0;  lsu_wm = '0;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        bus.ifu_req_valid = 1'b0;  bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b0;  bus.mem_resp_valid = 1'b0;
        bus.ifu_resp_ready = 1'b0;  bus.lsu_resp_ready = 1'b0;
        #2;
        chk_all_zero("post_reset");
        tick();

        // IFU alone, minimum latency
        ifu_pend = 1'b1;  ifu_a = 32'h8000_0000;
        serve("t1_ifu", 0, 0, 0, 1'b0, 32'h0010_0093);

        // LSU write with partial mask and some request backpressure
        lsu_pend = 1'b1;  lsu_a = 32'h8000_1000;  lsu_w = 1'b1;
        lsu_wd = 32'hA5A5_A5A5;  lsu_wm = 4'b0011;
        serve("t2_lsu_wr", 2, 0, 1, 1'b1, 32'h0);

        // Continuous contention: both requesters refilled after every pair
        for (int k = 0; k < 2; k++) begin
            ifu_pend = 1'b1;  ifu_a = 32'h8000_0100 + 32'(k * 4);
            lsu_pend = 1'b1;  lsu_a = 32'h8000_2000 + 32'(k * 8);  lsu_w = 1'b0;
            lsu_wd = 32'h0;  lsu_wm = 4'h0;
            serve("t3_first", 0, 0, 0, 1'b1, 32'h0);
            serve("t3_second", 0, 1, 0, 1'b1, 32'h0);
        end

        // Randomized traffic, every transaction short of the watchdog limit
        for (int n = 0; n < 60; n++) begin
            if (!ifu_pend && $urandom_range(1) == 1) begin
                ifu_pend = 1'b1;  ifu_a = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
            end
            if (!lsu_pend && ($urandom_range(1) == 1 || !ifu_pend)) begin
                lsu_pend = 1'b1;  lsu_a = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
                lsu_w = 1'($urandom);  lsu_wd = $urandom;  lsu_wm = 4'($urandom);
            end
            serve("rnd", $urandom_range(2), $urandom_range(1), $urandom_range(2), 1'b1, 32'h0);
        end

        // Watchdog: request stalled well past the limit
        ifu_pend = 1'b1;  ifu_a = 32'h8000_0040;
        serve("t5_timeout", 10, 0, 0, 1'b1, 32'h0);
        #2;
        chk1("t5_sticky", timeout_err, 1'b1);
        tick();

        // Backpressure on both sides with the other master contending
        ifu_pend = 1'b1;  ifu_a = 32'h8000_0080;
        lsu_pend = 1'b1;  lsu_a = 32'h8000_3000;  lsu_w = 1'b1;
        lsu_wd = 32'h0F0F_0F0F;  lsu_wm = 4'b1100;
        serve("t4_bp", 5, 0, 3, 1'b1, 32'h0);
        serve("t4_next", 0, 0, 0, 1'b1, 32'h0);

        // Reset while the arbiter is presenting a response
        ifu_pend = 1'b1;  ifu_a = 32'h8000_0200;
        bus.ifu_req_valid = 1'b1;  bus.ifu_addr = ifu_a;
        tick();
        bus.ifu_req_valid = 1'b0;  ifu_pend = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;  bus.mem_rdata = 32'hCAFE_F00D;
        bus.ifu_resp_ready = 1'b0;  bus.lsu_req_valid = 1'b1;
        #2;
        chk1("t6_in_resp", bus.ifu_resp_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        tick();
        tick();
        reset = 1'b1;
        bus.mem_resp_valid = 1'b0;  bus.lsu_req_valid = 1'b0;
        last_lsu_m = 1'b1;  exp_err = 1'b0;  lsu_pend = 1'b0;
        #2;
        chk_all_zero("t6_released");
        tick();
        ifu_pend = 1'b1;  ifu_a = 32'h8000_0300;
        serve("t6_after", 0, 0, 0, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
